// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-size encodings and the dump FSM state type.
package mips_pkg;

  localparam logic [1:0] LONG_BYTE = 2'b00;
  localparam logic [1:0] LONG_HALF = 2'b01;
  localparam logic [1:0] LONG_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/half of a little-endian word
// and sign- or zero-extends it to 32 bits.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_long,
  input  logic        i_sign,
  output logic [31:0] o_rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // lane select followed by extension; reserved size 10 falls through to word
  always_comb begin
    byte_s  = i_word[{i_addr_lo, 3'b000} +: 8];
    half_s  = i_word[{i_addr_lo[1], 4'b0000} +: 16];
    o_rdata = i_word;
    case (i_long)
      LONG_BYTE: o_rdata = {{24{i_sign & byte_s[7]}}, byte_s};
      LONG_HALF: o_rdata = {{16{i_sign & half_s[15]}}, half_s};
      default:   o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte/half/word loads and stores with misalignment
// suppression, plus a halted-mode valid/ready dump port streaming every word.
module mem_stage_dmem
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [1:0]        i_Long,
  input  logic              i_MemSign,
  input  logic              i_halted,
  input  logic              i_dump_start,
  input  logic              i_dump_ready,
  output logic [31:0]       o_rdata,
  output logic              o_misaligned,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [31:0]       o_dump_data,
  output logic              o_dump_busy,
  output logic              o_dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] word_idx_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       aligned_s;
  logic              mis_raw_s;
  logic              we_s;
  logic              addr_unused_s;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // upper address bits alias by design
  assign addr_unused_s = ^{i_addr[31:ADDR_W+2]};
  assign word_idx_s    = i_addr[ADDR_W+1:2];
  assign rd_word_s     = mem_q[word_idx_s];

  // alignment check on the raw address, independent of the enables
  always_comb begin
    mis_raw_s = 1'b0;
    case (i_Long)
      LONG_BYTE: mis_raw_s = 1'b0;
      LONG_HALF: mis_raw_s = i_addr[0];
      default:   mis_raw_s = (i_addr[1:0] != 2'b00);
    endcase
  end

  assign o_misaligned = (i_MemRead | i_MemWrite) & mis_raw_s;
  assign we_s         = i_MemWrite & ~mis_raw_s;

  load_align u_load_align (
    .i_word    (rd_word_s),
    .i_addr_lo (i_addr[1:0]),
    .i_long    (i_Long),
    .i_sign    (i_MemSign),
    .o_rdata   (aligned_s)
  );

  assign o_rdata = (i_MemRead & ~mis_raw_s) ? aligned_s : 32'd0;

  // merge store data into the current word so untouched lanes keep their value
  always_comb begin
    wr_word_s = rd_word_s;
    case (i_Long)
      LONG_BYTE: wr_word_s[{i_addr[1:0], 3'b000} +: 8]  = i_wdata[7:0];
      LONG_HALF: wr_word_s[{i_addr[1], 4'b0000} +: 16]  = i_wdata[15:0];
      default:   wr_word_s = i_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_s) mem_q[word_idx_s] <= wr_word_s;
  end

  // dump FSM next state; losing halted aborts without a done pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {ADDR_W{1'b0}};
        if (i_dump_start && i_halted) state_d = SEND;
        else                          state_d = IDLE;
      end
      SEND: begin
        if (!i_halted) begin
          state_d = IDLE;
          cnt_d   = {ADDR_W{1'b0}};
        end else if (i_dump_ready) begin
          if (cnt_q == LAST_IDX) state_d = DONE;
          else                   cnt_d = cnt_q + ADDR_W'(1);
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_dump_valid = (state_q == SEND);
  assign o_dump_addr  = cnt_q;
  assign o_dump_data  = mem_q[cnt_q];
  assign o_dump_busy  = (state_q != IDLE);
  assign o_dump_done  = (state_q == DONE);

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed self-checking bench for mem_stage_dmem (4-word array so the dump is short).
module tb_mem_stage_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_wdata;
  logic        i_MemRead, i_MemWrite, i_MemSign;
  logic [1:0]  i_Long;
  logic        i_halted, i_dump_start, i_dump_ready;
  logic [31:0] o_rdata, o_dump_data;
  logic        o_misaligned, o_dump_valid, o_dump_busy, o_dump_done;
  logic [1:0]  o_dump_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_dmem #(.DEPTH_WORDS(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_Long(i_Long),
    .i_MemSign(i_MemSign), .i_halted(i_halted), .i_dump_start(i_dump_start),
    .i_dump_ready(i_dump_ready), .o_rdata(o_rdata), .o_misaligned(o_misaligned),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    i_MemRead = 1'b0; i_MemWrite = 1'b0; i_Long = 2'b11; i_MemSign = 1'b0;
    i_addr = 32'd0; i_wdata = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
    i_addr = a; i_Long = l; i_wdata = d; i_MemWrite = 1'b1; i_MemRead = 1'b0;
    cyc();
    idle_bus();
  endtask

  task automatic setup_load(input logic [31:0] a, input logic [1:0] l, input logic s);
    i_addr = a; i_Long = l; i_MemSign = s; i_MemRead = 1'b1; i_MemWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_bus();
    i_halted = 1'b0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0; #1;
    n_cmp++; if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_dump_flags got %b want 000", {o_dump_valid, o_dump_busy, o_dump_done}); end
    n_cmp++; if (o_dump_addr !== 2'd0) begin
      n_fail++; $display("FAIL reset_dump_addr got %0d want 0", o_dump_addr); end
    i_addr = 32'h0000_0003;
    #1;
    n_cmp++; if ({o_rdata, o_misaligned} !== 33'd0) begin
      n_fail++; $display("FAIL reset_idle_bus got rdata=%h mis=%b want 0/0", o_rdata, o_misaligned); end
    idle_bus();
  endtask

  task automatic test_loads();
    logic [31:0] la [8] = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h11, 32'h11};
    logic [1:0]  ll [8] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        ls [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] le [8] = '{32'h8081_7F01, 32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                            32'hFFFF_8081, 32'h0000_8081, 32'h0000_007F, 32'h0000_0000};
    store(32'h10, 2'b11, 32'h8081_7F01);
    for (int i = 0; i < 8; i++) begin
      setup_load(la[i], ll[i], ls[i]);
      n_cmp++; if (o_rdata !== le[i] || o_misaligned !== (i == 7)) begin
        n_fail++; $display("FAIL load_%0d got rdata=%h mis=%b want %h", i, o_rdata, o_misaligned, le[i]); end
    end
    i_MemRead = 1'b0; i_addr = 32'h10; i_Long = 2'b11; #1;
    n_cmp++; if (o_rdata !== 32'd0) begin
      n_fail++; $display("FAIL load_disabled got %h want 0", o_rdata); end
    idle_bus();
  endtask

  task automatic test_subword_store();
    store(32'h20, 2'b11, 32'hAABB_CCDD);
    store(32'h21, 2'b00, 32'hFFFF_FF11);
    setup_load(32'h20, 2'b11, 1'b0);
    n_cmp++; if (o_rdata !== 32'hAABB_11DD) begin
      n_fail++; $display("FAIL store_byte got %h want AABB11DD", o_rdata); end
    idle_bus();
    store(32'h22, 2'b01, 32'h9999_2233);
    setup_load(32'h20, 2'b11, 1'b0);
    n_cmp++; if (o_rdata !== 32'h2233_11DD) begin
      n_fail++; $display("FAIL store_half got %h want 223311DD", o_rdata); end
    idle_bus();
  endtask

  task automatic test_misaligned();
    store(32'h04, 2'b11, 32'h1234_5678);
    i_addr = 32'h06; i_Long = 2'b11; i_wdata = 32'hDEAD_BEEF; i_MemWrite = 1'b1; #1;
    n_cmp++; if (o_misaligned !== 1'b1) begin
      n_fail++; $display("FAIL mis_store_flag got %b want 1", o_misaligned); end
    cyc(); idle_bus();
    setup_load(32'h04, 2'b11, 1'b0);
    n_cmp++; if (o_rdata !== 32'h1234_5678 || o_misaligned !== 1'b0) begin
      n_fail++; $display("FAIL mis_store_suppressed got %h want 12345678", o_rdata); end
    setup_load(32'h05, 2'b01, 1'b1);
    n_cmp++; if (o_rdata !== 32'd0 || o_misaligned !== 1'b1) begin
      n_fail++; $display("FAIL mis_load got rdata=%h mis=%b want 0/1", o_rdata, o_misaligned); end
    i_MemRead = 1'b0; #1;
    n_cmp++; if (o_misaligned !== 1'b0) begin
      n_fail++; $display("FAIL mis_gated got %b want 0", o_misaligned); end
    idle_bus();
  endtask

  task automatic test_same_cycle();
    i_addr = 32'h04; i_Long = 2'b11; i_wdata = 32'h0000_0055;
    i_MemWrite = 1'b1; i_MemRead = 1'b1; #1;
    n_cmp++; if (o_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL same_cycle_old got %h want 12345678", o_rdata); end
    cyc();
    i_MemWrite = 1'b0; #1;
    n_cmp++; if (o_rdata !== 32'h0000_0055) begin
      n_fail++; $display("FAIL same_cycle_new got %h want 00000055", o_rdata); end
    idle_bus();
  endtask

  task automatic test_dump();
    int dones = 0;
    for (int w = 0; w < 4; w++) store(32'(w * 4), 2'b11, 32'(w + 1));
    i_halted = 1'b1; i_dump_start = 1'b1; i_dump_ready = 1'b0;
    cyc();
    i_dump_start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      i_dump_ready = 1'b0; #1;
      n_cmp++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 2'(w) || o_dump_data !== 32'(w + 1)) begin
        n_fail++; $display("FAIL dump_word_%0d got v=%b a=%0d d=%h want 1/%0d/%0d", w, o_dump_valid, o_dump_addr, o_dump_data, w, w + 1); end
      cyc();
      n_cmp++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 2'(w) || o_dump_data !== 32'(w + 1)) begin
        n_fail++; $display("FAIL dump_hold_%0d got v=%b a=%0d d=%h", w, o_dump_valid, o_dump_addr, o_dump_data); end
      if (o_dump_done) dones++;
      i_dump_ready = 1'b1;
      i_dump_start = (w == 1);
      cyc();
      i_dump_start = 1'b0;
    end
    i_dump_ready = 1'b0; #1;
    if (o_dump_done) dones++;
    n_cmp++; if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0 || o_dump_busy !== 1'b1) begin
      n_fail++; $display("FAIL dump_done got done=%b v=%b busy=%b want 1/0/1", o_dump_done, o_dump_valid, o_dump_busy); end
    cyc();
    if (o_dump_done) dones++;
    n_cmp++; if (dones !== 1 || o_dump_busy !== 1'b0 || o_dump_addr !== 2'd0) begin
      n_fail++; $display("FAIL dump_idle got dones=%0d busy=%b want 1/0", dones, o_dump_busy); end
  endtask

  task automatic test_no_halt_and_abort();
    i_halted = 1'b0; i_dump_start = 1'b1;
    cyc();
    i_dump_start = 1'b0; #1;
    n_cmp++; if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0) begin
      n_fail++; $display("FAIL start_not_halted got v=%b busy=%b want 0/0", o_dump_valid, o_dump_busy); end
    i_halted = 1'b1; i_dump_start = 1'b1;
    cyc();
    i_dump_start = 1'b0; i_dump_ready = 1'b1;
    cyc(); cyc();
    i_dump_ready = 1'b0; i_halted = 1'b0; #1;
    n_cmp++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 2'd2) begin
      n_fail++; $display("FAIL abort_pre got v=%b a=%0d want 1/2", o_dump_valid, o_dump_addr); end
    cyc();
    n_cmp++; if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0 || o_dump_done !== 1'b0) begin
      n_fail++; $display("FAIL abort got v=%b busy=%b done=%b want 0/0/0", o_dump_valid, o_dump_busy, o_dump_done); end
    cyc();
    n_cmp++; if (o_dump_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done got %b want 0", o_dump_done); end
  endtask

  task automatic test_rst_mid_dump();
    i_halted = 1'b1; i_dump_start = 1'b1;
    cyc();
    i_dump_start = 1'b0; i_dump_ready = 1'b1;
    cyc(); cyc();
    i_dump_ready = 1'b0; #1;
    n_cmp++; if (o_dump_addr !== 2'd2 || o_dump_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got a=%0d v=%b want 2/1", o_dump_addr, o_dump_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    n_cmp++; if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got v=%b busy=%b want 0/0", o_dump_valid, o_dump_busy); end
    i_dump_start = 1'b1;
    cyc();
    i_dump_start = 1'b0; #1;
    n_cmp++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 2'd0 || o_dump_data !== 32'd1) begin
      n_fail++; $display("FAIL restart got v=%b a=%0d d=%h want 1/0/1", o_dump_valid, o_dump_addr, o_dump_data); end
    store(32'h00, 2'b11, 32'h0000_0077);
    n_cmp++; if (o_dump_data !== 32'h0000_0077 || o_dump_addr !== 2'd0) begin
      n_fail++; $display("FAIL dump_sees_store got %h want 00000077", o_dump_data); end
    i_halted = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_subword_store();
    test_misaligned();
    test_same_cycle();
    test_dump();
    test_no_halt_and_abort();
    test_rst_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
